// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: state encoding, default
// opcodes and the instruction decode used to pick the active data register.
package jtag_pkg;

    // Encoding follows the IEEE 1149.1 recommended state assignment
    typedef enum logic [3:0] {
        TLR   = 4'hF,
        RTI   = 4'hC,
        SelDR = 4'h7,
        CapDR = 4'h6,
        ShDR  = 4'h2,
        Ex1DR = 4'h1,
        PauDR = 4'h3,
        Ex2DR = 4'h0,
        UpdDR = 4'h5,
        SelIR = 4'h4,
        CapIR = 4'hE,
        ShIR  = 4'hA,
        Ex1IR = 4'h9,
        PauIR = 4'hB,
        Ex2IR = 4'h8,
        UpdIR = 4'hD
    } tapState_e;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_BOUNDARY
    } drSel_e;

    localparam int          IR_MAX_WIDTH         = 16;
    localparam logic [3:0]  DEFAULT_EXTEST       = 4'b0000;
    localparam logic [3:0]  DEFAULT_SAMPLE       = 4'b0001;
    localparam logic [3:0]  DEFAULT_IDCODE_OP    = 4'b0010;
    localparam logic [3:0]  DEFAULT_BYPASS       = 4'b1111;
    localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h1000_0A5B;

    // Operands are zero-extended so one function serves any IR width up to IR_MAX_WIDTH
    function automatic drSel_e decodeIr(
        input logic [IR_MAX_WIDTH-1:0] ir,
        input logic [IR_MAX_WIDTH-1:0] extestOp,
        input logic [IR_MAX_WIDTH-1:0] sampleOp,
        input logic [IR_MAX_WIDTH-1:0] idcodeOp,
        input logic [IR_MAX_WIDTH-1:0] bypassOp
    );
        if (ir == bypassOp) return SEL_BYPASS;
        if (ir == extestOp || ir == sampleOp) return SEL_BOUNDARY;
        if (ir == idcodeOp) return SEL_IDCODE;
        return SEL_BYPASS;
    endfunction

endpackage

// File: rtl/jtag_if.sv
// TAP-side pins and boundary-scan control strobes bundled as one interface.
interface jtag_if;
    import jtag_pkg::*;

    logic      TMS;
    logic      TDI;
    logic      TDO;
    logic      TDO_en;
    logic      BSChainIn;
    logic      CaptureDR;
    logic      ShiftDR;
    logic      UpdateDR;
    logic      sample_preload;
    logic      extest;
    tapState_e TapState;

    modport slave (
        input  TMS, TDI, BSChainIn,
        output TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR,
               sample_preload, extest, TapState
    );

    modport master (
        output TMS, TDI, BSChainIn,
        input  TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR,
               sample_preload, extest, TapState
    );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: state register plus next-state decode on TMS.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic      TCK,
    input  logic      TRST,
    input  logic      TMS,
    output tapState_e state
);

    tapState_e nextState;

    always_ff @(posedge TCK) begin
        if (TRST) state <= TLR;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            TLR:   nextState = TMS ? TLR   : RTI;
            RTI:   nextState = TMS ? SelDR : RTI;
            SelDR: nextState = TMS ? SelIR : CapDR;
            CapDR: nextState = TMS ? Ex1DR : ShDR;
            ShDR:  nextState = TMS ? Ex1DR : ShDR;
            Ex1DR: nextState = TMS ? UpdDR : PauDR;
            PauDR: nextState = TMS ? Ex2DR : PauDR;
            Ex2DR: nextState = TMS ? UpdDR : ShDR;
            UpdDR: nextState = TMS ? SelDR : RTI;
            SelIR: nextState = TMS ? TLR   : CapIR;
            CapIR: nextState = TMS ? Ex1IR : ShIR;
            ShIR:  nextState = TMS ? Ex1IR : ShIR;
            Ex1IR: nextState = TMS ? UpdIR : PauIR;
            PauIR: nextState = TMS ? Ex2IR : PauIR;
            Ex2IR: nextState = TMS ? UpdIR : ShIR;
            UpdIR: nextState = TMS ? SelDR : RTI;
        endcase
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: instruction register, BYPASS/IDCODE registers, boundary-scan
// strobes and the negedge-registered TDO mux around the TAP state machine.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int                     IR_WIDTH             = 4,
    parameter logic [31:0]            IDCODE_VALUE         = DEFAULT_IDCODE_VALUE,
    parameter logic [IR_WIDTH-1:0]    INSTR_EXTEST         = IR_WIDTH'(DEFAULT_EXTEST),
    parameter logic [IR_WIDTH-1:0]    INSTR_SAMPLE_PRELOAD = IR_WIDTH'(DEFAULT_SAMPLE),
    parameter logic [IR_WIDTH-1:0]    INSTR_IDCODE         = IR_WIDTH'(DEFAULT_IDCODE_OP),
    parameter logic [IR_WIDTH-1:0]    INSTR_BYPASS         = IR_WIDTH'(DEFAULT_BYPASS)
)
(
    input  logic   TCK,
    input  logic   TRST,
    jtag_if.slave  jtag
);

    tapState_e           state;
    logic [IR_WIDTH-1:0] irShift;
    logic [IR_WIDTH-1:0] irReg;
    logic [IR_WIDTH-1:0] activeIr;
    logic                bypassReg;
    logic [31:0]         idcodeReg;
    drSel_e              drSel;
    logic                boundarySel;
    logic                drBit;

    jtag_tap_fsm fsmInst (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (jtag.TMS),
        .state (state)
    );

    // TLR overrides the held instruction immediately, so reset takes effect at the posedge
    assign activeIr    = (state == TLR) ? INSTR_IDCODE : irReg;
    assign drSel       = decodeIr(IR_MAX_WIDTH'(activeIr), IR_MAX_WIDTH'(INSTR_EXTEST),
                                  IR_MAX_WIDTH'(INSTR_SAMPLE_PRELOAD), IR_MAX_WIDTH'(INSTR_IDCODE),
                                  IR_MAX_WIDTH'(INSTR_BYPASS));
    assign boundarySel = (drSel == SEL_BOUNDARY);

    assign jtag.CaptureDR      = boundarySel && (state == CapDR);
    assign jtag.ShiftDR        = boundarySel && (state == ShDR);
    assign jtag.UpdateDR       = boundarySel && (state == UpdDR);
    assign jtag.sample_preload = (activeIr == INSTR_SAMPLE_PRELOAD);
    assign jtag.extest         = (activeIr == INSTR_EXTEST);
    assign jtag.TapState       = state;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            irShift <= '0;
        end else if (state == CapIR) begin
            irShift <= IR_WIDTH'(2'b01);
        end else if (state == ShIR) begin
            irShift <= {jtag.TDI, irShift[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            bypassReg <= 1'b0;
            idcodeReg <= IDCODE_VALUE;
        end else begin
            if (drSel == SEL_BYPASS) begin
                if (state == CapDR)     bypassReg <= 1'b0;
                else if (state == ShDR) bypassReg <= jtag.TDI;
            end
            if (drSel == SEL_IDCODE) begin
                if (state == CapDR)     idcodeReg <= IDCODE_VALUE;
                else if (state == ShDR) idcodeReg <= {jtag.TDI, idcodeReg[31:1]};
            end
        end
    end

    always_ff @(negedge TCK) begin
        if (state == TLR)        irReg <= INSTR_IDCODE;
        else if (state == UpdIR) irReg <= irShift;
    end

    always_comb begin
        drBit = bypassReg;
        case (drSel)
            SEL_BOUNDARY: drBit = jtag.BSChainIn;
            SEL_IDCODE:   drBit = idcodeReg[0];
            default:      drBit = bypassReg;
        endcase
    end

    // TDO keeps its last value outside the shift states; only the enable drops
    always_ff @(negedge TCK) begin
        if (state == TLR) begin
            jtag.TDO    <= 1'b0;
            jtag.TDO_en <= 1'b0;
        end else if (state == ShIR) begin
            jtag.TDO    <= irShift[0];
            jtag.TDO_en <= 1'b1;
        end else if (state == ShDR) begin
            jtag.TDO    <= drBit;
            jtag.TDO_en <= 1'b1;
        end else begin
            jtag.TDO_en <= 1'b0;
        end
    end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller for the DCD JTAG chain. It sits directly upstream of the boundary-scan cells and contains the 16-state TAP FSM, the instruction register, the BYPASS and IDCODE data registers, and the TDO output mux. It generates the CaptureDR/ShiftDR/UpdateDR strobes and the sample_preload select consumed by every jtag_InputCell in the chain. The chain output returns to this block through BSChainIn.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_VALUE, 32'h1000_0A5B, value captured into IDCODE register; bit0 must be 1
INSTR_EXTEST, 4'b0000, boundary-scan EXTEST opcode
INSTR_SAMPLE_PRELOAD, 4'b0001, boundary-scan SAMPLE/PRELOAD opcode
INSTR_IDCODE, 4'b0010, IDCODE opcode
INSTR_BYPASS, 4'b1111, BYPASS opcode

Ports:
TCK  input  1  test clock; the only clock (both edges used)
TRST  input  1  synchronous active-high reset, sampled on posedge TCK
TMS  input  1  test mode select
TDI  input  1  test data in
TDO  output  1  test data out, registered on negedge TCK
TDO_en  output  1  TDO output enable, registered on negedge TCK
BSChainIn  input  1  ToNextBSCell of the last boundary-scan cell
CaptureDR  output  1  boundary chain capture strobe
ShiftDR  output  1  boundary chain shift strobe
UpdateDR  output  1  boundary chain update strobe
sample_preload  output  1  active instruction is SAMPLE/PRELOAD
extest  output  1  active instruction is EXTEST
TapState  output  4  current FSM state, for debug

Behaviour:
- FSM: standard 16 states (TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR). Transitions are per 1149.1 on posedge TCK using TMS. Encoding is a shared-package enum.
- TRST=1 at a posedge: state<=TLR, IR<=INSTR_IDCODE, bypass<=0. At the next negedge: TDO<=0, TDO_en<=0.
- From any state, five consecutive TMS=1 posedges reach TLR. In TLR the active IR is forced to INSTR_IDCODE on every posedge.
- IR shift register, IR_WIDTH bits:
  - CapIR: load {0...,2'b01}.
  - ShIR: shift right, TDI into MSB; bit0 feeds TDO.
  - UpdIR: active IR <= shift reg on negedge TCK. It is unchanged elsewhere.
- Decode of active IR:
  - EXTEST or SAMPLE_PRELOAD: boundary chain is selected.
  - IDCODE: IDCODE register is selected.
  - Any other code, including unassigned ones: BYPASS is selected.
- Outputs sample_preload and extest are combinational from the active IR. They change only on the UpdIR negedge or on reset.
- Boundary strobes are combinational from state AND boundary-selected:
  - CaptureDR = CapDR.
  - ShiftDR = ShDR.
  - UpdateDR = UpdDR, held for the whole state so the cell's negedge update samples it high.
  - All three are 0 when boundary is not selected.
- BYPASS register: CapDR loads 0; ShDR loads TDI. Only active when selected.
- IDCODE register, 32 bits: CapDR loads IDCODE_VALUE; ShDR shifts right with TDI into bit31. Only active when selected.
- TDO mux, registered on negedge TCK:
  - ShIR: IR shift bit0.
  - ShDR: selected register bit0 (BSChainIn / bypass / idcode[0]).
  - Otherwise TDO holds its value and TDO_en=0.
  - TDO_en=1 only on negedges while in ShIR or ShDR.
- Pause and Exit states hold all shift registers unchanged.
- TRST asserted mid-shift: shift contents are discarded and the active IR becomes IDCODE. Any UpdDR/UpdIR pending in that cycle is not performed.

Decomposition:
- Package jtag_pkg holds:
  - the TAP state enum and its 4-bit encoding;
  - default opcodes and IDCODE_VALUE;
  - an IR-decode function.
- One natural sub-module, jtag_tap_fsm, containing only the state register and next-state logic.
- IR, data registers and TDO mux stay in jtag_tap_controller.

Test Plan:
- Assert TRST one posedge -> TapState=TLR, sample_preload=0, extest=0, TDO_en=0. Then TMS=0 -> RTI.
- From ShDR, apply TMS=1 for five clocks -> TLR reached on the 5th posedge. Active IR reads back IDCODE.
- After reset, go to ShDR and shift 32 bits with TDI=0 -> TDO sequence, LSB first, equals 32'h1000_0A5B, with TDO_en=1 throughout.
- Shift IR=4'b0001 then pass UpdIR:
  - captured IR bits out on TDO = 1,0,0,0;
  - sample_preload rises at the UpdIR negedge;
  - CapDR/ShDR/UpdDR each assert their strobe for exactly the states' duration;
  - BSChainIn appears on TDO one negedge later.
- Load IR=4'b0111 (unassigned) -> BYPASS is selected. Shift 1,0,1,1 on TDI -> TDO=0 (captured),1,0,1. All boundary strobes stay 0.
- Assert TRST during ShIR after 2 bits -> next state TLR, active IR=IDCODE, no update performed, TDO_en=0 at the following negedge.
